// File: rtl/demux4_reg.sv
`default_nettype none

`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

// ============================================================================
// Module      : demux4_reg
// Description : Registered 1-to-4 demultiplexer with valid/ready handshake.
//               It steers one producer stream into one of four consumer
//               channels chosen by in_select. Each channel has its own
//               one-entry holding register, so a stalled consumer blocks
//               only beats addressed to it and never the other three.
//               Each channel also counts the beats it has delivered, with
//               silent wrap-around.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1        rising-edge clock
//   reset         in   1        asynchronous, active-high reset
//   flush         in   1        synchronous drop of all held entries
//   in_valid      in   1        producer presents a beat
//   in_ready      out  1        block accepts the beat this cycle
//   in_select     in   2        destination channel 0..3
//   in_data       in   DATA_W   payload
//   out_valid     out  4        per-channel holding register full
//   out_ready     in   4        per-channel consumer accepts
//   out_data_N    out  DATA_W   channel N payload (N = 0..3)
//   out_count_N   out  CNT_W    beats delivered on channel N (wraps)
// ============================================================================
module demux4_reg #(
    parameter int DATA_W = `DATA_SIZE,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_select,
    input  logic [DATA_W-1:0] in_data,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data_0,
    output logic [DATA_W-1:0] out_data_1,
    output logic [DATA_W-1:0] out_data_2,
    output logic [DATA_W-1:0] out_data_3,
    output logic [CNT_W-1:0]  out_count_0,
    output logic [CNT_W-1:0]  out_count_1,
    output logic [CNT_W-1:0]  out_count_2,
    output logic [CNT_W-1:0]  out_count_3
);

    // Holding-register states
    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]        w_full;
    logic [3:0]        w_deliver;
    logic [3:0]        w_load;
    logic [3:0]        w_sel_dec;
    logic              w_accept;
    logic [DATA_W-1:0] w_data  [4];
    logic [CNT_W-1:0]  w_count [4];

    // ------------------------------------------------------------------------
    // Input side. in_ready looks only at the addressed channel: it can take
    // a beat when empty, or when full but draining this same cycle. in_ready
    // never depends on in_valid, so no combinational loop forms through a
    // producer that waits for ready.
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready = ~flush & (~w_full[in_select] | out_ready[in_select]);
    end

    // in_valid gates every state update, so X on in_select or in_data while
    // idle cannot reach any register.
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_sel_dec = 4'b0000;
        case (in_select)
            2'd0:    w_sel_dec = 4'b0001;
            2'd1:    w_sel_dec = 4'b0010;
            2'd2:    w_sel_dec = 4'b0100;
            2'd3:    w_sel_dec = 4'b1000;
            default: w_sel_dec = 4'b0000;
        endcase
    end

    // ------------------------------------------------------------------------
    // Per-channel holding register, state machine and delivery counter
    // ------------------------------------------------------------------------
    for (genvar n = 0; n < 4; n++) begin : g_ch
        logic [0:0]        r_state;
        logic [0:0]        w_state_nxt;
        logic [DATA_W-1:0] r_data;
        logic [CNT_W-1:0]  r_count;

        assign w_load[n]    = w_accept & w_sel_dec[n];
        assign w_deliver[n] = w_full[n] & out_ready[n];

        // State register
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= c_EMPTY;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // Next-state logic. Flush wins over everything; an accept cannot
        // coincide with a flush because in_ready is low then. A refill in
        // the same cycle as a delivery keeps the channel FULL, which gives
        // one beat per cycle of throughput.
        always_comb begin
            w_state_nxt = r_state;
            if (flush) begin
                w_state_nxt = c_EMPTY;
            end else if (w_load[n]) begin
                w_state_nxt = c_FULL;
            end else if (w_deliver[n]) begin
                w_state_nxt = c_EMPTY;
            end
        end

        // Output logic
        always_comb begin
            w_full[n] = (r_state == c_FULL);
        end

        // Payload is written only on accept. It is deliberately not cleared
        // on delivery or flush; consumers qualify it with out_valid.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_data <= '0;
            end else if (w_load[n]) begin
                r_data <= in_data;
            end
        end

        // A delivery counts even in a flush cycle, since the consumer took
        // the beat on that edge.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_count <= '0;
            end else if (w_deliver[n]) begin
                r_count <= r_count + c_CNT_ONE;
            end
        end

        assign w_data[n]  = r_data;
        assign w_count[n] = r_count;
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign out_valid   = w_full;
    assign out_data_0  = w_data[0];
    assign out_data_1  = w_data[1];
    assign out_data_2  = w_data[2];
    assign out_data_3  = w_data[3];
    assign out_count_0 = w_count[0];
    assign out_count_1 = w_count[1];
    assign out_count_2 = w_count[2];
    assign out_count_3 = w_count[3];

endmodule

`default_nettype wire
